// File: rtl/addsub_seq_ctrl_if.sv
// Request/result handshake bundle for addsub_seq_ctrl.
// Define ADDSUB_SEQ_FLAGS_EN to add the zero_flag/neg_flag result qualifiers.
interface addsub_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;
`ifdef ADDSUB_SEQ_FLAGS_EN
  logic             zero_flag;
  logic             neg_flag;

  modport master (
    output start_valid, op_a, op_b, op_sub, res_ready,
    input  start_ready, res_valid, result, carry_out, overflow, busy,
           zero_flag, neg_flag
  );

  modport slave (
    input  start_valid, op_a, op_b, op_sub, res_ready,
    output start_ready, res_valid, result, carry_out, overflow, busy,
           zero_flag, neg_flag
  );
`else
  modport master (
    output start_valid, op_a, op_b, op_sub, res_ready,
    input  start_ready, res_valid, result, carry_out, overflow, busy
  );

  modport slave (
    input  start_valid, op_a, op_b, op_sub, res_ready,
    output start_ready, res_valid, result, carry_out, overflow, busy
  );
`endif
endinterface

// File: rtl/addsub_seq_ctrl.sv
// Multi-word add/subtract built from a 4-bit slice, one nibble per clock, LSB first.
// Optional feature macro: ADDSUB_SEQ_FLAGS_EN (adds registered zero_flag / neg_flag).
module addsub_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  addsub_seq_ctrl_if.slave   bus
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [NIB-1:0][3:0]    a_q;
  logic [NIB-1:0][3:0]    b_q;
  logic                   sub_q;
  logic [IDXW-1:0]        idx;
  logic                   cin_q;
  logic [NIB-1:0][3:0]    result_q;
  logic                   carry_q;
  logic                   ovf_q;
  logic                   res_valid_q;
  logic                   start_ready_q;
  logic                   busy_q;

  logic [3:0]             a_nib;
  logic [3:0]             b_nib;
  logic [4:0]             slice_sum;
  logic                   c3;
  logic                   c4;
  logic                   last_nib;
  logic [NIB-1:0][3:0]    result_next;

  // The 4-bit slice; carry into bit 3 is recovered from the sum bit and its two inputs.
  always_comb begin
    a_nib       = a_q[idx];
    b_nib       = b_q[idx] ^ {4{sub_q}};
    slice_sum   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, cin_q};
    c4          = slice_sum[4];
    c3          = a_nib[3] ^ b_nib[3] ^ slice_sum[3];
    last_nib    = (idx == IDXW'(NIB - 1));
    result_next = result_q;
    result_next[idx] = slice_sum[3:0];
  end

`ifdef ADDSUB_SEQ_FLAGS_EN
  logic zero_q;
  logic neg_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      sub_q         <= 1'b0;
      idx           <= '0;
      cin_q         <= 1'b0;
      result_q      <= '0;
      carry_q       <= 1'b0;
      ovf_q         <= 1'b0;
      res_valid_q   <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
`ifdef ADDSUB_SEQ_FLAGS_EN
      zero_q        <= 1'b0;
      neg_q         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_q           <= bus.op_a;
            b_q           <= bus.op_b;
            sub_q         <= bus.op_sub;
            cin_q         <= bus.op_sub;
            idx           <= '0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          result_q <= result_next;
          cin_q    <= c4;
          if (last_nib) begin
            carry_q     <= c4;
            ovf_q       <= c3 ^ c4;
            idx         <= '0;
            res_valid_q <= 1'b1;
            state       <= DONE;
`ifdef ADDSUB_SEQ_FLAGS_EN
            zero_q      <= (result_next == '0);
            neg_q       <= result_next[NIB-1][3];
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // start_ready only returns here, so a new request waits for the next IDLE edge.
          if (bus.res_ready) begin
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          res_valid_q   <= 1'b0;
          busy_q        <= 1'b0;
          start_ready_q <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.result      = result_q;
  assign bus.carry_out   = carry_q;
  assign bus.overflow    = ovf_q;
  assign bus.busy        = busy_q;
`ifdef ADDSUB_SEQ_FLAGS_EN
  assign bus.zero_flag   = zero_q;
  assign bus.neg_flag    = neg_q;
`endif

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Scoreboard bench for addsub_seq_ctrl (WIDTH=16): directed corners plus random operations.
// Flag outputs are checked when ADDSUB_SEQ_FLAGS_EN is defined.
module tb_addsub_seq_ctrl;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk;
  logic rst_n;

  addsub_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  addsub_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    logic             z;
    logic             n;
  } exp_t;

  exp_t expq[$];
  int   compared   = 0;
  int   mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: whole-word arithmetic with integer signed-range test for overflow.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
    exp_t e;
    int   sa, sb, sr;
    longint ua, ub, ur;
    ua = longint'(a);
    ub = longint'(b);
    ur = sub ? (ua - ub + 65536) : (ua + ub);
    e.r = ur[WIDTH-1:0];
    e.c = sub ? (ua >= ub) : (ur >= 65536);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sr = sub ? (sa - sb) : (sa + sb);
    e.v = (sr > 32767) || (sr < -32768);
    e.z = (e.r == '0);
    e.n = e.r[WIDTH-1];
    return e;
  endfunction

  // Monitor: compares on every result handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_result", 32'(bus.result), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = expq.pop_front();
        checkOutput("result", 32'(bus.result), 32'(e.r));
        checkOutput("carry_out", 32'(bus.carry_out), 32'(e.c));
        checkOutput("overflow", 32'(bus.overflow), 32'(e.v));
`ifdef ADDSUB_SEQ_FLAGS_EN
        checkOutput("zero_flag", 32'(bus.zero_flag), 32'(e.z));
        checkOutput("neg_flag", 32'(bus.neg_flag), 32'(e.n));
`endif
      end
    end
  end

  // Presents a request and returns just after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
    bit ok;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.op_sub      = sub;
    bus.start_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.start_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.start_valid = 1'b0;
    if (ok) expq.push_back(model(a, b, sub));
    else    checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Counts edges from the accepting edge (counted as 1) to the edge that raises res_valid.
  task automatic waitResult(output int lat);
    lat = 1;
    while (bus.res_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.res_valid !== 1'b1) checkOutput("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub, input int hold);
    int lat;
    bus.res_ready = (hold == 0);
    applyStimulus(a, b, sub);
    waitResult(lat);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic [WIDTH-1:0] held_r;
    logic held_c, held_v;

    bus.start_valid = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    bus.op_sub      = 1'b0;
    bus.res_ready   = 1'b1;
    rst_n           = 1'b1;

    // Reset asserted mid-clock
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_result", 32'(bus.result), 32'd0);
    checkOutput("rst_carry", 32'(bus.carry_out), 32'd0);
    checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_start_ready", 32'(bus.start_ready), 32'd1);

    // Basic add with latency and single-cycle valid
    bus.res_ready = 1'b1;
    applyStimulus(16'h1234, 16'h0FFF, 1'b0);
    checkOutput("run_start_ready", 32'(bus.start_ready), 32'd0);
    checkOutput("run_busy", 32'(bus.busy), 32'd1);
    waitResult(lat);
    checkOutput("latency", 32'(lat), 32'(NIB + 1));
    @(posedge clk);
    #1;
    checkOutput("valid_one_cycle", 32'(bus.res_valid), 32'd0);
    checkOutput("busy_after", 32'(bus.busy), 32'd0);

    // Signed overflow corners
    runOp(16'h7FFF, 16'h0001, 1'b0, 0);
    runOp(16'h8000, 16'h0001, 1'b1, 0);
    runOp(16'h0002, 16'h0003, 1'b1, 0);

    // Backpressure with a pending request and changing operands
    bus.res_ready = 1'b0;
    applyStimulus(16'hA5A5, 16'h1111, 1'b1);
    waitResult(lat);
    held_r = bus.result;
    held_c = bus.carry_out;
    held_v = bus.overflow;
    checkOutput("bp_result_value", 32'(held_r), 32'h9494);
    bus.start_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.op_a   = 16'($urandom);
      bus.op_b   = 16'($urandom);
      bus.op_sub = 1'($urandom);
      @(posedge clk);
      #1;
      checkOutput("bp_result_stable", 32'(bus.result), 32'(held_r));
      checkOutput("bp_carry_stable", 32'(bus.carry_out), 32'(held_c));
      checkOutput("bp_ovf_stable", 32'(bus.overflow), 32'(held_v));
      checkOutput("bp_start_ready", 32'(bus.start_ready), 32'd0);
      checkOutput("bp_valid_held", 32'(bus.res_valid), 32'd1);
    end
    bus.res_ready = 1'b1;
    applyStimulus(16'h4321, 16'h1234, 1'b0);
    waitResult(lat);
    @(posedge clk);
    #1;

    // Reset after two nibbles of a RUN
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    expq.delete();
    #1;
    checkOutput("midrst_result", 32'(bus.result), 32'd0);
    checkOutput("midrst_carry", 32'(bus.carry_out), 32'd0);
    checkOutput("midrst_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
`ifdef ADDSUB_SEQ_FLAGS_EN
    checkOutput("midrst_zero_flag", 32'(bus.zero_flag), 32'd0);
    checkOutput("midrst_neg_flag", 32'(bus.neg_flag), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_start_ready", 32'(bus.start_ready), 32'd1);
    runOp(16'h0005, 16'h0005, 1'b1, 0);

    // Random operations with random result backpressure
    for (int i = 0; i < 24; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 6 == 0) ra = 16'h8000;
      if (i % 6 == 1) rb = 16'hFFFF;
      runOp(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("queue_drained", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
